// File: rtl/updown_count_decoder.sv
// updown_count_decoder: passive monitor that recovers direction, steps, wraps, holds,
// reversals and illegal jumps from a sampled up/down count bus.
// Optional: define UPDOWN_COUNT_DECODER_ERR_CNT_EN to build the saturating err_cnt register.
module updown_count_decoder #(
   parameter int WIDTH = 4,
   parameter int RUN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             dir_valid,
   output logic             step_up,
   output logic             step_down,
   output logic             wrap_up,
   output logic             wrap_down,
   output logic             hold,
   output logic             reversal,
   output logic             err,
   output logic [RUN_W-1:0] run_len,
   output logic [7:0]       err_cnt
);
   typedef enum logic [1:0] {IDLE, PRIMED, UP, DOWN} state_e;
   state_e           state_q;
   logic [WIDTH-1:0] prev_q, delta;
   logic [RUN_W-1:0] run_q, run_inc;
   logic             dir_q, dir_valid_q, step_up_q, step_down_q, wrap_up_q, wrap_down_q;
   logic             hold_q, reversal_q, err_q;
   logic             is_up, is_dn, is_hold, is_err;
   // Classify the step; a 1-bit bus resolves its ambiguous delta from the current direction
   always_comb begin
      delta   = count - prev_q;
      is_up   = (delta == WIDTH'(1)) && ((WIDTH > 1) || state_q == UP || state_q == PRIMED);
      is_dn   = (&delta) && !is_up;
      is_hold = delta == '0;
      is_err  = !(is_up || is_dn || is_hold);
      run_inc = (&run_q) ? run_q : run_q + RUN_W'(1);
   end
   // Decoder FSM with registered direction, run length and one-cycle pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         run_q       <= '0;
         dir_q       <= 1'b0;
         dir_valid_q <= 1'b0;
         step_up_q   <= 1'b0;
         step_down_q <= 1'b0;
         wrap_up_q   <= 1'b0;
         wrap_down_q <= 1'b0;
         hold_q      <= 1'b0;
         reversal_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         step_up_q   <= 1'b0;
         step_down_q <= 1'b0;
         wrap_up_q   <= 1'b0;
         wrap_down_q <= 1'b0;
         hold_q      <= 1'b0;
         reversal_q  <= 1'b0;
         err_q       <= 1'b0;
         if (en) begin
            prev_q <= count;
            if (state_q == IDLE) begin
               state_q <= PRIMED;
            end else begin
               step_up_q   <= is_up;
               step_down_q <= is_dn;
               wrap_up_q   <= is_up && (&prev_q);
               wrap_down_q <= is_dn && (prev_q == '0);
               hold_q      <= is_hold;
               err_q       <= is_err;
               if (is_up) begin
                  state_q     <= UP;
                  dir_q       <= 1'b1;
                  dir_valid_q <= 1'b1;
                  reversal_q  <= state_q == DOWN;
                  run_q       <= state_q == UP ? run_inc : RUN_W'(1);
               end else if (is_dn) begin
                  state_q     <= DOWN;
                  dir_q       <= 1'b0;
                  dir_valid_q <= 1'b1;
                  reversal_q  <= state_q == UP;
                  run_q       <= state_q == DOWN ? run_inc : RUN_W'(1);
               end else if (is_err) begin
                  state_q     <= PRIMED;
                  dir_valid_q <= 1'b0;
                  run_q       <= '0;
               end
            end
         end
      end
   end
`ifdef UPDOWN_COUNT_DECODER_ERR_CNT_EN
   logic [7:0] err_cnt_q;
   // Saturating count of illegal jumps, cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_cnt_q <= '0;
      else if (en && state_q != IDLE && is_err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
   end
   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = '0;
`endif
   assign dir       = dir_q;
   assign dir_valid = dir_valid_q;
   assign step_up   = step_up_q;
   assign step_down = step_down_q;
   assign wrap_up   = wrap_up_q;
   assign wrap_down = wrap_down_q;
   assign hold      = hold_q;
   assign reversal  = reversal_q;
   assign err       = err_q;
   assign run_len   = run_q;
endmodule

// File: tb/tb_updown_count_decoder.sv
// tb_updown_count_decoder: directed checks of the up/down count decoder with WIDTH=4.
module tb_updown_count_decoder;
   localparam logic [6:0] SU = 7'b1000000, SD = 7'b0100000, WU = 7'b0010000, WD = 7'b0001000;
   localparam logic [6:0] HO = 7'b0000100, RV = 7'b0000010, ER = 7'b0000001;
   logic       clk = 1'b0, rst, en;
   logic [3:0] count;
   logic       dir, dir_valid, step_up, step_down, wrap_up, wrap_down, hold, reversal, err;
   logic [7:0] run_len, err_cnt;
   logic [7:0] exp_ec;
   int         tests = 0, fails = 0;
   updown_count_decoder #(.WIDTH(4), .RUN_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .count(count), .dir(dir), .dir_valid(dir_valid),
      .step_up(step_up), .step_down(step_down), .wrap_up(wrap_up), .wrap_down(wrap_down),
      .hold(hold), .reversal(reversal), .err(err), .run_len(run_len), .err_cnt(err_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_out(input string tag, input logic [6:0] f, input logic d, input logic dv, input logic [7:0] r);
      chk({tag, " flags"}, 32'({step_up, step_down, wrap_up, wrap_down, hold, reversal, err}), 32'(f));
      chk({tag, " dir"}, 32'(dir), 32'(d));
      chk({tag, " dir_valid"}, 32'(dir_valid), 32'(dv));
      chk({tag, " run_len"}, 32'(run_len), 32'(r));
      chk({tag, " err_cnt"}, 32'(err_cnt), 32'(exp_ec));
   endtask
   task automatic s(input string tag, input logic e, input logic [3:0] c, input logic [6:0] f, input logic d, input logic dv, input logic [7:0] r);
      en = e;
      count = c;
      @(posedge clk);
      #1;
      chk_out(tag, f, d, dv, r);
   endtask
   task automatic do_reset(input string tag);
      en = 1'b0;
      rst = 1'b0;
      exp_ec = 8'd0;
      #1;
      chk_out(tag, 7'd0, 1'b0, 1'b0, 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask
   initial begin
      rst = 1'b0;
      en = 1'b0;
      count = 4'd0;
      exp_ec = 8'd0;
      @(posedge clk);
      #1;
      chk_out("por", 7'd0, 1'b0, 1'b0, 8'd0);
      rst = 1'b1;
      s("up prime", 1, 4'd0, 7'd0, 0, 0, 8'd0);
      for (int i = 1; i < 16; i++) s("up run", 1, 4'(i), SU, 1, 1, 8'(i));
      s("up wrap", 1, 4'd0, SU | WU, 1, 1, 8'd16);
      s("up after wrap", 1, 4'd1, SU, 1, 1, 8'd17);
      do_reset("rst2");
      s("dn prime", 1, 4'd5, 7'd0, 0, 0, 8'd0);
      s("dn 5-4", 1, 4'd4, SD, 0, 1, 8'd1);
      s("dn 4-3", 1, 4'd3, SD, 0, 1, 8'd2);
      s("rev 3-4", 1, 4'd4, SU | RV, 1, 1, 8'd1);
      s("up 4-5", 1, 4'd5, SU, 1, 1, 8'd2);
      do_reset("rst3");
      s("he prime", 1, 4'd2, 7'd0, 0, 0, 8'd0);
      s("he 2-3", 1, 4'd3, SU, 1, 1, 8'd1);
      s("hold 3-3", 1, 4'd3, HO, 1, 1, 8'd1);
`ifdef UPDOWN_COUNT_DECODER_ERR_CNT_EN
      exp_ec = 8'd1;
`endif
      s("err 3-9", 1, 4'd9, ER, 1, 0, 8'd0);
      s("up 9-10", 1, 4'd10, SU, 1, 1, 8'd1);
      do_reset("rst4");
      s("gate prime", 1, 4'd0, 7'd0, 0, 0, 8'd0);
      s("gate 0-1", 1, 4'd1, SU, 1, 1, 8'd1);
      for (int i = 0; i < 3; i++) s("gate off", 0, 4'd7, 7'd0, 1, 1, 8'd1);
      s("gate 1-2", 1, 4'd2, SU, 1, 1, 8'd2);
      do_reset("rst5");
      s("ar prime", 1, 4'd0, 7'd0, 0, 0, 8'd0);
      for (int i = 1; i < 7; i++) s("ar run", 1, 4'(i), SU, 1, 1, 8'(i));
      #2;
      rst = 1'b0;
      exp_ec = 8'd0;
      #1;
      chk_out("async rst", 7'd0, 0, 0, 8'd0);
      #1;
      rst = 1'b1;
      s("ar first 7", 1, 4'd7, 7'd0, 0, 0, 8'd0);
      s("ar 7-8", 1, 4'd8, SU, 1, 1, 8'd1);
      do_reset("rst6");
      s("wd prime", 1, 4'd1, 7'd0, 0, 0, 8'd0);
      s("wd 1-0", 1, 4'd0, SD, 0, 1, 8'd1);
      s("wd 0-15", 1, 4'd15, SD | WD, 0, 1, 8'd2);
      s("wd 15-14", 1, 4'd14, SD, 0, 1, 8'd3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
